rot: RTL and testbench

ROT -- requirements
Module: rot

---
 rtl/rot.sv | 134 +++++++++++++
 tb/tb_rot.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rot.sv
// ============================================================================
// Module   : rot
// Brief    : Two-stage pipelined 2-D vector rotator. It uses a quarter-wave
//            sine ROM, and derives full-circle sin/cos from quadrant symmetry.
// Config   : ROT_ROUND_EN - when defined, rounds the rescaled sums half toward
//            +infinity. When undefined, the result is floored by an
//            arithmetic shift.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rot #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [9:0]        theta,
  output logic [DATA_W-1:0] rx,
  output logic [DATA_W-1:0] ry
);

  // Fixed-point precision used only while building the ROM at elaboration.
  localparam int     C_FRAC    = 30;
  localparam longint C_ONE_Q30 = longint'(1) <<< C_FRAC;
  localparam longint C_PI_Q30  = 64'd3373259426;  // pi * 2^30
  localparam int     C_PW      = 2 * DATA_W + 1;  // product width
  localparam int     C_SW      = 2 * DATA_W + 2;  // sum width (one guard bit)

`ifdef ROT_ROUND_EN
  localparam logic signed [C_SW-1:0] C_RND = C_SW'(longint'(1) <<< (DATA_W - 2));
`else
  localparam logic signed [C_SW-1:0] C_RND = '0;
`endif

  // round(sin(k*pi/512) * 2^(DATA_W-1)), evaluated with a Taylor series in
  // Q30 integer arithmetic so that the table is a pure elaboration constant.
  function automatic logic [DATA_W:0] sin_entry(input int k);
    longint a;
    longint term;
    longint acc;
    a    = (longint'(k) * C_PI_Q30) / 512;
    term = a;
    acc  = a;
    for (int n = 1; n <= 9; n++) begin
      term = (term * a) / C_ONE_Q30;
      term = (term * a) / C_ONE_Q30;
      term = -(term / longint'((2 * n) * (2 * n + 1)));
      acc  = acc + term;
    end
    acc = (acc + (longint'(1) <<< (C_FRAC - DATA_W))) >>> (C_FRAC - DATA_W + 1);
    return acc[DATA_W:0];
  endfunction

  // Quarter-wave table, 0..90 deg inclusive; entry 256 is exactly SCALE.
  logic [DATA_W:0] rom [0:256];

  for (genvar k = 0; k <= 256; k++) begin : g_rom
    localparam logic [DATA_W:0] C_V = sin_entry(k);
    assign rom[k] = C_V;
  end

  logic [9:0]               ang_c;
  logic [8:0]               sin_idx;
  logic [8:0]               cos_idx;
  logic [DATA_W:0]          sin_mag;
  logic [DATA_W:0]          cos_mag;

  logic signed [DATA_W-1:0] x_d,   x_q;
  logic signed [DATA_W-1:0] y_d,   y_q;
  logic signed [DATA_W:0]   sin_d, sin_q;
  logic signed [DATA_W:0]   cos_d, cos_q;

  logic signed [C_PW-1:0]   xcos_val, xsin_val, ycos_val, ysin_val;
  logic signed [C_SW-1:0]   rx_t, ry_t;
  logic [DATA_W-1:0]        rx_d, rx_q;
  logic [DATA_W-1:0]        ry_d, ry_q;

  // Stage-1 next state: capture inputs and fold theta onto the quarter-wave ROM.
  always_comb begin
    x_d     = $signed(x);
    y_d     = $signed(y);
    ang_c   = theta + 10'd256;  // cos(a) = sin(a + 90 deg), wraps mod 1024
    sin_idx = theta[8] ? (9'd256 - {1'b0, theta[7:0]}) : {1'b0, theta[7:0]};
    cos_idx = ang_c[8] ? (9'd256 - {1'b0, ang_c[7:0]}) : {1'b0, ang_c[7:0]};
    sin_mag = rom[sin_idx];
    cos_mag = rom[cos_idx];
    sin_d   = theta[9] ? -$signed(sin_mag) : $signed(sin_mag);
    cos_d   = ang_c[9] ? -$signed(cos_mag) : $signed(cos_mag);
  end

  // Stage-2 next state: full-precision products, guarded sums, then rescale.
  always_comb begin
    xcos_val = $signed({{(DATA_W + 1){x_q[DATA_W-1]}}, x_q}) *
               $signed({{DATA_W{cos_q[DATA_W]}}, cos_q});
    xsin_val = $signed({{(DATA_W + 1){x_q[DATA_W-1]}}, x_q}) *
               $signed({{DATA_W{sin_q[DATA_W]}}, sin_q});
    ycos_val = $signed({{(DATA_W + 1){y_q[DATA_W-1]}}, y_q}) *
               $signed({{DATA_W{cos_q[DATA_W]}}, cos_q});
    ysin_val = $signed({{(DATA_W + 1){y_q[DATA_W-1]}}, y_q}) *
               $signed({{DATA_W{sin_q[DATA_W]}}, sin_q});
    rx_t     = $signed({xcos_val[C_PW-1], xcos_val}) - $signed({ysin_val[C_PW-1], ysin_val});
    ry_t     = $signed({xsin_val[C_PW-1], xsin_val}) + $signed({ycos_val[C_PW-1], ycos_val});
    // Truncation to DATA_W bits wraps out-of-range results on purpose.
    rx_d     = DATA_W'((rx_t + C_RND) >>> (DATA_W - 1));
    ry_d     = DATA_W'((ry_t + C_RND) >>> (DATA_W - 1));
  end

  // Pipeline registers; reset clears every stage so nothing in flight survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      sin_q <= '0;
      cos_q <= '0;
      rx_q  <= '0;
      ry_q  <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      sin_q <= sin_d;
      cos_q <= cos_d;
      rx_q  <= rx_d;
      ry_q  <= ry_d;
    end
  end

  assign rx = rx_q;
  assign ry = ry_q;

endmodule

`default_nettype wire

// File: tb/tb_rot.sv
// ============================================================================
// Module   : tb_rot
// Brief    : Scoreboard bench for rot. The driver queues expected results
//            with a due cycle, and the monitor compares them at that cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rot;

  localparam int  DATA_W = 10;
  localparam real PI     = 3.14159265358979;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic [9:0]        theta;
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] ry;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int    due;
    real   erx;
    real   ery;
    real   tol;
    string name;
  } exp_t;

  exp_t sb[$];

  rot #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .y     (y),
    .theta (theta),
    .rx    (rx),
    .ry    (ry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Present one input set for one cycle and queue its result, due two edges later.
  task automatic drive(input logic r, input int xi, input int yi, input int th,
                       input real erx, input real ery, input real tol, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst   = r;
    x     = DATA_W'(xi);
    y     = DATA_W'(yi);
    theta = 10'(th);
    e.due  = cyc + 2;
    e.erx  = erx;
    e.ery  = ery;
    e.tol  = tol;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: on each falling edge, retire every entry that is due this cycle.
  initial begin
    exp_t e;
    int   ax;
    int   ay;
    real  dx;
    real  dy;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e  = sb.pop_front();
        ax = $signed(rx);
        ay = $signed(ry);
        checks = checks + 2;
        if (e.due < cyc) begin
          failures = failures + 2;
          $display("FAIL %s missed: due cycle %0d, seen at %0d", e.name, e.due, cyc);
        end else begin
          dx = $itor(ax) - e.erx;
          dy = $itor(ay) - e.ery;
          if (dx < 0.0) dx = -dx;
          if (dy < 0.0) dy = -dy;
          if (dx > e.tol + 1.0e-6) begin
            failures = failures + 1;
            $display("FAIL %s rx: got %0d, expected %0.3f (tol %0.2f)", e.name, ax, e.erx, e.tol);
          end
          if (dy > e.tol + 1.0e-6) begin
            failures = failures + 1;
            $display("FAIL %s ry: got %0d, expected %0.3f (tol %0.2f)", e.name, ay, e.ery, e.tol);
          end
        end
      end
    end
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    real a;
    int  th;
`ifdef ROT_ROUND_EN
    int  r640 = -7;
`else
    int  r640 = -8;
`endif
    rst   = 1'b1;
    x     = '0;
    y     = '0;
    theta = '0;

    // Reset held: outputs stay 0 even with live inputs.
    drive(1'b1, 10, 0, 0, 0.0, 0.0, 0.0, "reset_hold0");
    drive(1'b1, 10, 0, 0, 0.0, 0.0, 0.0, "reset_hold1");

    // Directed cardinal and diagonal angles.
    drive(1'b0, 10,   0,   0,  10.0,   0.0, 0.0, "t0");
    drive(1'b0, 10,   0, 256,   0.0,  10.0, 0.0, "t256");
    drive(1'b0, 10,   0, 512, -10.0,   0.0, 0.0, "t512");
    drive(1'b0, 10,   0, 768,   0.0, -10.0, 0.0, "t768");
    drive(1'b0, 10,   0, 128,   7.0,   7.0, 0.0, "t128");
    drive(1'b0, 10,   0, 640, $itor(r640), $itor(r640), 0.0, "t640");
    drive(1'b0,  0,  10, 256, -10.0,   0.0, 0.0, "y_t256");
    drive(1'b0, -512, 0, 512, -512.0,  0.0, 0.0, "wrap_neg512");
    drive(1'b0, 100, 50, 256, -50.0, 100.0, 0.0, "xy_t256");
    drive(1'b0,  3,  -7, 512,  -3.0,   7.0, 0.0, "xy_t512");

    // Sweep one theta per cycle; a one-edge reset at step 100 flushes the
    // sample about to leave stage 1 and the sample being captured.
    for (int i = 0; i < 256; i++) begin
      th = i * 4;
      a  = $itor(th) * 2.0 * PI / 1024.0;
      if (i == 99)
        drive(1'b0, 10, 0, th, 0.0, 0.0, 0.0, "sweep_flushed");
      else if (i == 100)
        drive(1'b1, 10, 0, th, 0.0, 0.0, 0.0, "sweep_rst");
      else
        drive(1'b0, 10, 0, th, 10.0 * $cos(a), 10.0 * $sin(a), 1.02, "sweep");
    end

    // Continuity across the 1023 -> 0 wrap.
    for (int i = 0; i < 3; i++) begin
      th = (1023 + i) % 1024;
      a  = $itor(th) * 2.0 * PI / 1024.0;
      drive(1'b0, 10, 0, th, 10.0 * $cos(a), 10.0 * $sin(a), 1.02, "theta_wrap");
    end

    // Drain the pipeline, then confirm that every queued result was retired.
    @(posedge clk);
    #1;
    x     = '0;
    theta = '0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      failures = failures + 1;
      $display("FAIL drain: %0d results never appeared, expected 0 pending", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
